// File: rtl/wf_led_driver.sv
// User LED output stage: turns a registered mode/level setting (off, steady, blink,
// breathe) into a PWM waveform. The PWM duty only changes at frame wrap, so the pin
// never shows a partial frame.
module wf_led_driver #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned TICK_DIV    = 62500,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic                WF_CLK,
  input  logic                WF_RST,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  output logic                WF_LED,
  output logic [PWM_BITS-1:0] duty,
  output logic                tick
);

  localparam int unsigned PresW  = $clog2(TICK_DIV);
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PresW-1:0]    PresMax  = PresW'(TICK_DIV - 1);
  localparam logic [PresW-1:0]    PresOne  = PresW'(1);
  localparam logic [BlinkW-1:0]   BlinkMax = BlinkW'(BLINK_TICKS - 1);
  localparam logic [BlinkW-1:0]   BlinkOne = BlinkW'(1);
  localparam logic [PWM_BITS-1:0] PwmMax   = '1;
  localparam logic [PWM_BITS-1:0] PwmOne   = PWM_BITS'(1);

  typedef enum logic [1:0] {
    ModeOff     = 2'd0,
    ModeOn      = 2'd1,
    ModeBlink   = 2'd2,
    ModeBreathe = 2'd3
  } mode_e;

  mode_e               mode_q, mode_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PresW-1:0]    presc_q, presc_d;
  logic [BlinkW-1:0]   bcnt_q, bcnt_d;
  logic                phase_q, phase_d;   // 1 = blink on-phase
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                down_q, down_d;     // breathe direction, 1 = ramping down
  logic                tick_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [PWM_BITS-1:0] duty_q;
  logic                led_q;
  logic [PWM_BITS-1:0] duty_next;

  // Duty requested by the current pattern; sampled only at PWM wrap.
  always_comb begin
    duty_next = '0;
    unique case (mode_q)
      ModeOff:     duty_next = '0;
      ModeOn:      duty_next = level_q;
      ModeBlink:   duty_next = phase_q ? level_q : '0;
      ModeBreathe: duty_next = ramp_q;
      default:     duty_next = '0;
    endcase
  end

  // Config latch, prescaler and pattern stepping; a write restarts the pattern and
  // masks any tick that coincides with it.
  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    presc_d = presc_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    ramp_d  = ramp_q;
    down_d  = down_q;
    if (cfg_we) begin
      mode_d  = mode_e'(cfg_mode);
      level_d = cfg_level;
      presc_d = '0;
      bcnt_d  = '0;
      phase_d = 1'b1;
      ramp_d  = '0;
      down_d  = 1'b0;
    end else begin
      presc_d = (presc_q == PresMax) ? '0 : presc_q + PresOne;
      if (tick_q) begin
        if (bcnt_q == BlinkMax) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + BlinkOne;
        end
        // Triangle ramp between 0 and level_q; turns around without wrapping.
        if (!down_q) begin
          if (ramp_q < level_q) begin
            ramp_d = ramp_q + PwmOne;
          end else begin
            down_d = 1'b1;
            if (ramp_q != '0) ramp_d = ramp_q - PwmOne;
          end
        end else begin
          if (ramp_q != '0) begin
            ramp_d = ramp_q - PwmOne;
          end else begin
            down_d = 1'b0;
            if (level_q != '0) ramp_d = ramp_q + PwmOne;
          end
        end
      end
    end
  end

  // All state, synchronous reset with priority over configuration writes.
  always_ff @(posedge WF_CLK) begin
    if (WF_RST) begin
      mode_q  <= ModeOff;
      level_q <= '0;
      presc_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      ramp_q  <= '0;
      down_q  <= 1'b0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
      duty_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      level_q <= level_d;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      ramp_q  <= ramp_d;
      down_q  <= down_d;
      // The prescaler restarts on a write, so a pulse from the old count is dropped.
      tick_q  <= (presc_q == PresMax) && !cfg_we;
      pwm_q   <= pwm_q + PwmOne;
      if (pwm_q == PwmMax) duty_q <= duty_next;
      led_q   <= (pwm_q < duty_q);
    end
  end

  assign WF_LED = led_q;
  assign duty   = duty_q;
  assign tick   = tick_q;

endmodule

// File: doc/wf_led_driver.md
# wf_led_driver

Output stage for the on-board user LED: sits directly downstream of the board's blink/status logic and drives the `WF_LED` pin. It converts a registered mode/level configuration (off, steady, blink, breathe) into an 8-bit PWM waveform. Duty changes are applied only at PWM frame boundaries, so the LED never glitches. Intended for the 16 MHz `WF_CLK` domain.

## Interface
- `PWM_BITS`, 8, width of the PWM counter, level and duty (frame = 2^PWM_BITS cycles)
- `TICK_DIV`, 62500, `WF_CLK` cycles per step tick (256 ticks/s at 16 MHz); must be >= 2
- `BLINK_TICKS`, 256, ticks per blink half-period (1 s on / 1 s off at defaults); must be >= 1
- `WF_CLK`  in  1  sole clock, all logic on rising edge
- `WF_RST`  in  1  reset, synchronous, active-high
- `cfg_we`  in  1  one-cycle write strobe for `cfg_mode`/`cfg_level`
- `cfg_mode`  in  2  0 = OFF, 1 = ON, 2 = BLINK, 3 = BREATHE
- `cfg_level`  in  PWM_BITS  brightness: ON/BLINK duty, BREATHE peak
- `WF_LED`  out  1  registered PWM output to the LED pin
- `duty`  out  PWM_BITS  duty currently applied (`duty_active`)
- `tick`  out  1  one-cycle prescaler pulse

## Operation
- Reset (`WF_RST` high at a clock edge): `mode_r` = OFF, `level_r` = 0, prescaler = 0, `pwm_cnt` = 0, `duty_active` = 0, blink count = 0, phase = on, ramp = 0, ramp dir = UP, `WF_LED` = 0, `tick` = 0. Reset has priority over `cfg_we`.
- Prescaler: counts 0..TICK_DIV-1, then wraps to 0. `tick` is registered high for exactly one cycle on the cycle after the count reaches TICK_DIV-1.
- PWM: `pwm_cnt` free-runs 0..2^PWM_BITS-1 and wraps. When `pwm_cnt` = max, `duty_active` <= `duty_next`. Every cycle, `WF_LED` <= (`pwm_cnt` < `duty_active`).
  - Duty 0: LED always off.
  - Duty 255: LED on for 255 of every 256 cycles.
- Config write: `cfg_we` latches mode and level, then restarts the pattern state:
  - prescaler = 0, blink count = 0, phase = on, ramp = 0, dir = UP.
  - This applies to every write, including rewriting the same mode.
  - `pwm_cnt` and `duty_active` are not disturbed.
- `duty_next` per mode:
  - OFF: 0.
  - ON: `level_r`.
  - BLINK: phase ? `level_r` : 0. On each tick the blink count increments. At count = BLINK_TICKS-1, phase toggles and the count returns to 0.
  - BREATHE: `duty_next` = ramp. On each tick:
    - UP: if ramp < `level_r`, ramp+1; otherwise dir <= DOWN and ramp-1 (if ramp > 0).
    - DOWN: if ramp > 0, ramp-1; otherwise dir <= UP and ramp+1 (if `level_r` > 0).
    - `level_r` = 0 holds ramp at 0.
    - Ramp arithmetic never wraps.
- Tick and `cfg_we` in the same cycle: the write wins, and the tick is ignored by the pattern logic.

## Timing
- `cfg_we` at edge N: `mode_r`/`level_r` are valid after N. The new duty reaches `duty_active` at the first PWM wrap after N, and `WF_LED` reflects it one cycle later.
- Worst-case write-to-LED latency: 2^PWM_BITS + 1 cycles.
- BREATHE full cycle at level L: 2L ticks (triangle 0 -> L -> 0).
- BLINK period: 2·BLINK_TICKS ticks.
- Pattern state changes only on tick edges. The LED sees a change only at frame granularity.
- Reset mid-operation: `WF_LED` is 0 on the cycle after the reset edge; OFF is held until a new write.

## Test plan
- Reset: hold `WF_RST` 3 cycles, then release with no write -> `WF_LED` = 0 and `duty` = 0 forever; first `tick` exactly TICK_DIV cycles after release.
- ON, level 64 -> after the first wrap, `duty` = 64 and `WF_LED` is high for exactly 64 consecutive cycles of every 256. Rewrite level 0 -> `WF_LED` stays 0 after the next wrap.
- BLINK, level 255, TICK_DIV = 256, BLINK_TICKS = 2 -> `duty` alternates 255 for 2 frames and 0 for 2 frames. The first on-frame follows the write.
- BREATHE, level 3, TICK_DIV = 256 -> successive tick-sampled `duty` values 0,1,2,3,2,1,0,1,2,3. Never exceeds 3, never underflows.
- Write ON level 10 mid-breathe (ramp = 2, DOWN) -> `duty` = 10 at the next wrap. A subsequent BREATHE write restarts at ramp 0, UP.
- `cfg_we` and `WF_RST` in the same cycle during BLINK with `WF_LED` high -> reset wins: `WF_LED` = 0 next cycle, mode OFF, no blink resumes.
